// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO with flush and a registered head entry.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_next_s;

  // Next occupancy and next head; the head register is preloaded so decode sees flop outputs.
  always_comb begin
    count_next_s = count_r;
    head_next_s  = head_r;
    if (push && !pop) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (pop && !push) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
    if (pop) begin
      if (count_r == CNT_W'(1)) begin
        head_next_s = push ? push_data : head_r;
      end else begin
        head_next_s = mem_r[rd_ptr_r + PTR_W'(1)];
      end
    end else if (count_r == CNT_W'(0) && push) begin
      head_next_s = push_data;
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage, pointers, occupancy and head register; flush leaves the stale head behind an empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      head_r  <= head_next_s;
    end
  end

  assign head_data = head_r;
  assign count     = count_r;
  assign empty     = (count_r == CNT_W'(0));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, BOOT/RUN sequencing, and push/pop/redirect arbitration
// in front of a combinational instruction memory.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                 BITSIZE    = INSTR_W,
  parameter int                 REGSIZE    = ADDR_W,
  parameter logic [REGSIZE-1:0] RESET_PC   = REGSIZE'(RESET_PC_DEFAULT),
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [REGSIZE-1:0] imem_addr,
  input  logic [BITSIZE-1:0] imem_data,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [REGSIZE-1:0] redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [BITSIZE-1:0] if_instr,
  output logic [REGSIZE-1:0] if_pc
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = REGSIZE + BITSIZE;

  fetch_state_e       state_r;
  fetch_state_e       state_next_s;
  logic [REGSIZE-1:0] pc_r;
  logic [REGSIZE-1:0] pc_next_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] head_s;

  // A redirect kills both transfers in its cycle so nothing from the old path survives the flush.
  assign pop_s  = !fifo_empty_s && if_ready && !redirect_valid;
  assign push_s = (state_r == RUN) && fetch_en && !redirect_valid &&
                  ((fifo_count_s < CNT_W'(FIFO_DEPTH)) || pop_s);

  // Next state and next PC.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      BOOT:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = BOOT;
    endcase
    if (redirect_valid) begin
      pc_next_s = {redirect_pc[REGSIZE-1:2], 2'b00};
    end else if (push_s) begin
      pc_next_s = pc_r + REGSIZE'(PC_STEP);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .push_data ({pc_r, imem_data}),
    .head_data (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign imem_addr = {2'b00, pc_r[REGSIZE-1:2]};
  assign if_valid  = !fifo_empty_s;
  assign if_pc     = head_s[BITSIZE +: REGSIZE];
  assign if_instr  = head_s[BITSIZE-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table plus hand sequences for
// drain with fetch disabled, redirect during BOOT and asynchronous mid-run reset.
module tb_instruction_fetch;

  localparam logic [31:0] I0 = 32'h002081F3;
  localparam logic [31:0] I1 = 32'h002091F3;
  localparam logic [31:0] I2 = 32'h0020A1F3;
  localparam logic [31:0] I3 = 32'h00001003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] rom [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vec [14];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd16) ? rom[imem_addr[3:0]] : 32'hDEAD_BEEF;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [31:0] epc,
                            input logic [31:0] einstr, input logic [31:0] eaddr);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, ev});
    check({tag, ".addr"}, imem_addr, eaddr);
    if (ev) begin
      check({tag, ".pc"}, if_pc, epc);
      check({tag, ".instr"}, if_instr, einstr);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 32'h0000_1000 + 32'(k);
    rom[0] = I0;
    rom[1] = I1;
    rom[2] = I2;

    // ready low fills the buffer, then pops under full, redirect to 7, fetch_en low drain
    vec[0]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I0,    32'd1};
    vec[2]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I0,    32'd2};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I0,    32'd2};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I0,    32'd2};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, I0,    32'd2};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, I1,    32'd3};
    vec[7]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, I2,    32'd4};
    vec[8]  = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, I2,    32'd4};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 32'h7, 1'b0, 32'h0, 32'h0, 32'd1};
    vec[10] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, I1,    32'd2};
    vec[11] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd2};
    vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd2};
    vec[13] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, I2,    32'd3};

    // Reset values while rst_n is held low
    #12;
    expect_out("reset", 1'b0, 32'h0, 32'h0, 32'd0);
    check("reset.pc", if_pc, 32'h0);
    check("reset.instr", if_instr, 32'h0);

    // Basic streaming with ready high: BOOT cycle then 0, 4, 8
    fetch_en = 1'b1;
    if_ready = 1'b1;
    do_reset();
    tick(); expect_out("boot", 1'b0, 32'h0, 32'h0, 32'd0);
    tick(); expect_out("s0",   1'b1, 32'h0, I0,    32'd1);
    tick(); expect_out("s1",   1'b1, 32'h4, I1,    32'd2);
    tick(); expect_out("s2",   1'b1, 32'h8, I2,    32'd3);

    // Table run from a fresh reset
    if_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      fetch_en       = vec[i].fe;
      if_ready       = vec[i].rdy;
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      tick();
      expect_out($sformatf("vec%0d", i), vec[i].ev, vec[i].epc, vec[i].einstr, vec[i].eaddr);
    end
    redirect_valid = 1'b0;

    // Two buffered entries drain with fetch disabled, then fetch resumes from the held pc
    fetch_en = 1'b1;
    if_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    expect_out("fill", 1'b1, 32'h0, I0, 32'd2);
    fetch_en = 1'b0;
    if_ready = 1'b1;
    tick(); expect_out("drain0", 1'b1, 32'h4, I1, 32'd2);
    tick(); expect_out("drain1", 1'b0, 32'h0, 32'h0, 32'd2);
    tick(); expect_out("drain2", 1'b0, 32'h0, 32'h0, 32'd2);
    fetch_en = 1'b1;
    tick(); expect_out("resume0", 1'b1, 32'h8, I2, 32'd3);
    tick(); expect_out("resume1", 1'b1, 32'hC, I3, 32'd4);

    // Redirect arriving in the BOOT cycle is honoured
    rst_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_000B;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); expect_out("bootredir", 1'b0, 32'h0, 32'h0, 32'd2);
    redirect_valid = 1'b0;
    tick(); expect_out("bootredir1", 1'b1, 32'h8, I2, 32'd3);

    // Asynchronous reset between clock edges, then the BOOT cycle repeats
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async", 1'b0, 32'h0, 32'h0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); expect_out("reboot", 1'b0, 32'h0, 32'h0, 32'd0);
    tick(); expect_out("reboot1", 1'b1, 32'h0, I0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
